// File: rtl/lc3_regfile_sb_if.sv
// Bus bundle for the LC-3 register file: writeback, condition-code load, read ports
// and the issue handshake of the busy scoreboard.
interface lc3_regfile_sb_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREG);

    logic                 LD_REG;
    logic [AW-1:0]        DR;
    logic [WIDTH-1:0]     BUS;
    logic                 LD_CC;
    logic [NRD*AW-1:0]    SR_SEL;
    logic [NRD*WIDTH-1:0] SR_OUT;
    logic [NRD-1:0]       SR_BUSY;
    logic                 ISSUE_VALID;
    logic [AW-1:0]        ISSUE_DR;
    logic                 ISSUE_READY;
    logic [2:0]           NZP;

    modport master (
        output LD_REG, DR, BUS, LD_CC, SR_SEL, ISSUE_VALID, ISSUE_DR,
        input  SR_OUT, SR_BUSY, ISSUE_READY, NZP
    );

    modport slave (
        input  LD_REG, DR, BUS, LD_CC, SR_SEL, ISSUE_VALID, ISSUE_DR,
        output SR_OUT, SR_BUSY, ISSUE_READY, NZP
    );
endinterface

// File: rtl/lc3_regfile_sb.sv
// Parametrised register file with optional write-to-read bypass, a per-register busy
// scoreboard guarding in-flight destinations, and the NZP condition-code register.
module lc3_regfile_sb #(
    parameter int WIDTH  = 16,
    parameter int NREG   = 8,
    parameter int NRD    = 2,
    parameter bit BYPASS = 1'b1
) (
    input logic            Clk,
    input logic            Reset_n,
    lc3_regfile_sb_if.slave rf
);
    localparam int AW = $clog2(NREG);

    logic [WIDTH-1:0]     regs_r [NREG];
    logic [NREG-1:0]      busy_r;
    logic [NREG-1:0]      busy_nxt_s;
    logic [2:0]           nzp_r;
    logic                 issue_ready_s;
    logic [NRD*WIDTH-1:0] sr_out_s;
    logic [NRD-1:0]       sr_busy_s;

    function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
        logic is_zero;
        is_zero = (v == {WIDTH{1'b0}});
        return {v[WIDTH-1], is_zero, ~v[WIDTH-1] & ~is_zero};
    endfunction

    // Read ports: a same-cycle writeback to the selected register is forwarded when bypass is on
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] sel_s;
        logic          hit_s;
        assign sel_s = rf.SR_SEL[gi*AW +: AW];
        assign hit_s = BYPASS & rf.LD_REG & (rf.DR == sel_s);
        assign sr_out_s[gi*WIDTH +: WIDTH] = hit_s ? rf.BUS : regs_r[sel_s];
        assign sr_busy_s[gi] = busy_r[sel_s] & ~hit_s;
    end

    // Issue acceptance and next scoreboard state; issue is applied last so the new owner wins
    always_comb begin
        issue_ready_s = ~busy_r[rf.ISSUE_DR] | (rf.LD_REG & (rf.DR == rf.ISSUE_DR));
        busy_nxt_s    = busy_r;
        if (rf.LD_REG) begin
            busy_nxt_s[rf.DR] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (rf.ISSUE_VALID & issue_ready_s) begin
            busy_nxt_s[rf.ISSUE_DR] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Register storage, scoreboard and condition codes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            busy_r <= {NREG{1'b0}};
            nzp_r  <= 3'b010;
        end else begin
            if (rf.LD_REG) begin
                regs_r[rf.DR] <= rf.BUS;
            end
            if (rf.LD_CC) begin
                nzp_r <= cc_of(rf.BUS);
            end
            busy_r <= busy_nxt_s;
        end
    end

    assign rf.SR_OUT      = sr_out_s;
    assign rf.SR_BUSY     = sr_busy_s;
    assign rf.ISSUE_READY = issue_ready_s;
    assign rf.NZP         = nzp_r;
endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based model,
// on a bypassing 8x16 file, a non-bypassing twin, and a 16x32 three-port variant.
module tb_lc3_regfile_sb;
    logic Clk = 1'b0;
    logic Reset_n;
    int   total = 0;
    int   bad = 0;

    always #5 Clk = ~Clk;

    lc3_regfile_sb_if #(.WIDTH(16), .NREG(8),  .NRD(2)) ifa ();
    lc3_regfile_sb_if #(.WIDTH(16), .NREG(8),  .NRD(2)) ifb ();
    lc3_regfile_sb_if #(.WIDTH(32), .NREG(16), .NRD(3)) ifc ();

    assign ifb.LD_REG      = ifa.LD_REG;
    assign ifb.DR          = ifa.DR;
    assign ifb.BUS         = ifa.BUS;
    assign ifb.LD_CC       = ifa.LD_CC;
    assign ifb.SR_SEL      = ifa.SR_SEL;
    assign ifb.ISSUE_VALID = ifa.ISSUE_VALID;
    assign ifb.ISSUE_DR    = ifa.ISSUE_DR;

    lc3_regfile_sb #(.WIDTH(16), .NREG(8), .NRD(2), .BYPASS(1'b1)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .rf(ifa));
    lc3_regfile_sb #(.WIDTH(16), .NREG(8), .NRD(2), .BYPASS(1'b0)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .rf(ifb));
    lc3_regfile_sb #(.WIDTH(32), .NREG(16), .NRD(3), .BYPASS(1'b1)) dut_c (
        .Clk(Clk), .Reset_n(Reset_n), .rf(ifc));

    // Reference state for the two 8x16 instances
    logic [15:0] m_reg [8];
    logic [7:0]  m_busy;
    logic [2:0]  m_nzp;
    logic        last_acc = 1'b0;

    function automatic logic [2:0] cc(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        else if (v == 16'h0000) return 3'b010;
        else return 3'b001;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        m_busy = 8'h00;
        m_nzp  = 3'b010;
    endtask

    task automatic set_in(input logic ld, input logic [2:0] dr, input logic [15:0] bus,
                          input logic ldcc, input logic [2:0] s0, input logic [2:0] s1,
                          input logic iv, input logic [2:0] idr);
        ifa.LD_REG = ld; ifa.DR = dr; ifa.BUS = bus; ifa.LD_CC = ldcc;
        ifa.SR_SEL = {s1, s0}; ifa.ISSUE_VALID = iv; ifa.ISSUE_DR = idr;
    endtask

    task automatic check_ab(input string tag);
        logic [2:0] s;
        logic       hit;
        logic       rdy;
        for (int p = 0; p < 2; p++) begin
            s   = ifa.SR_SEL[p*3 +: 3];
            hit = ifa.LD_REG && (ifa.DR == s);
            chk($sformatf("%s_a_out%0d", tag, p), ifa.SR_OUT[p*16 +: 16], hit ? ifa.BUS : m_reg[s]);
            chk($sformatf("%s_b_out%0d", tag, p), ifb.SR_OUT[p*16 +: 16], m_reg[s]);
            chk($sformatf("%s_a_busy%0d", tag, p), ifa.SR_BUSY[p], m_busy[s] && !hit);
            chk($sformatf("%s_b_busy%0d", tag, p), ifb.SR_BUSY[p], m_busy[s]);
        end
        rdy = !m_busy[ifa.ISSUE_DR] || (ifa.LD_REG && ifa.DR == ifa.ISSUE_DR);
        chk({tag, "_a_ready"}, ifa.ISSUE_READY, rdy);
        chk({tag, "_b_ready"}, ifb.ISSUE_READY, rdy);
        chk({tag, "_a_nzp"}, ifa.NZP, m_nzp);
        chk({tag, "_b_nzp"}, ifb.NZP, m_nzp);
    endtask

    // Check current outputs, take one clock edge, advance the model
    task automatic tick(input string tag);
        logic rdy;
        #1;
        check_ab(tag);
        rdy = !m_busy[ifa.ISSUE_DR] || (ifa.LD_REG && ifa.DR == ifa.ISSUE_DR);
        @(posedge Clk);
        last_acc = ifa.ISSUE_VALID && rdy;
        if (ifa.LD_REG) begin
            m_reg[ifa.DR]  = ifa.BUS;
            m_busy[ifa.DR] = 1'b0;
        end
        if (last_acc) m_busy[ifa.ISSUE_DR] = 1'b1;
        if (ifa.LD_CC) m_nzp = cc(ifa.BUS);
        #1;
    endtask

    initial begin
        logic [3:0] sv [3];
        Reset_n = 1'b0;
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        ifc.LD_REG = 1'b0; ifc.DR = 4'd0; ifc.BUS = 32'h0; ifc.LD_CC = 1'b0;
        ifc.SR_SEL = 12'h000; ifc.ISSUE_VALID = 1'b0; ifc.ISSUE_DR = 4'd0;
        model_reset();
        @(posedge Clk);
        #1;
        check_ab("reset");
        chk("reset_nzp", ifa.NZP, 3'b010);
        Reset_n = 1'b1;

        // Same-cycle write and read of register 5
        set_in(1'b1, 3'd5, 16'h1234, 1'b0, 3'd5, 3'd0, 1'b0, 3'd0);
        #1;
        chk("byp_a_now", ifa.SR_OUT[15:0], 16'h1234);
        chk("byp_b_now", ifb.SR_OUT[15:0], 16'h0000);
        tick("byp");
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd0, 1'b0, 3'd0);
        #1;
        chk("byp_b_next", ifb.SR_OUT[15:0], 16'h1234);
        tick("byp_next");

        // Issue register 2, observe it busy, then write it back
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 1'b1, 3'd2);
        tick("iss2");
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 1'b0, 3'd2);
        #1;
        chk("iss2_ready", ifa.ISSUE_READY, 1'b0);
        chk("iss2_busy1", ifa.SR_BUSY[1], 1'b1);
        tick("iss2_busy");
        set_in(1'b1, 3'd2, 16'h0202, 1'b0, 3'd0, 3'd2, 1'b0, 3'd2);
        tick("wb2");
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 1'b0, 3'd0);
        #1;
        chk("wb2_busy1", ifa.SR_BUSY[1], 1'b0);
        tick("wb2_after");

        // Writeback and re-issue of register 4 on the same edge
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1, 3'd4);
        tick("iss4");
        set_in(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 3'd0, 1'b1, 3'd4);
        #1;
        chk("wbiss4_ready", ifa.ISSUE_READY, 1'b1);
        tick("wbiss4");
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd4, 3'd0, 1'b0, 3'd4);
        #1;
        chk("wbiss4_busy", ifa.SR_BUSY[0], 1'b1);
        chk("wbiss4_val", ifa.SR_OUT[15:0], 16'h4444);
        chk("wbiss4_rdy", ifa.ISSUE_READY, 1'b0);
        tick("wbiss4_after");
        set_in(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        tick("wb4");

        // Condition-code loads
        set_in(1'b0, 3'd0, 16'h8000, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0);
        tick("cc_neg");
        chk("cc_neg", ifa.NZP, 3'b100);
        set_in(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0);
        tick("cc_zero");
        chk("cc_zero", ifa.NZP, 3'b010);
        set_in(1'b1, 3'd6, 16'h0001, 1'b1, 3'd0, 3'd0, 1'b0, 3'd0);
        tick("cc_pos");
        chk("cc_pos", ifa.NZP, 3'b001);

        // Mid-cycle reset with register 3 written and busy
        set_in(1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 3'd0, 1'b0, 3'd0);
        tick("beef");
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd0, 1'b1, 3'd3);
        tick("iss3");
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 3'd0, 1'b0, 3'd0);
        #1;
        chk("pre_rst_val", ifa.SR_OUT[15:0], 16'hBEEF);
        chk("pre_rst_busy", ifa.SR_BUSY[0], 1'b1);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_val", ifa.SR_OUT[15:0], 16'h0000);
        chk("rst_busy", ifa.SR_BUSY[0], 1'b0);
        chk("rst_nzp", ifa.NZP, 3'b010);
        check_ab("rst_mid");
        for (int i = 0; i < 8; i++) begin
            ifa.ISSUE_DR = 3'(i);
            #1;
            chk($sformatf("rst_ready%0d", i), ifa.ISSUE_READY, 1'b1);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        last_acc = 1'b0;

        // Random traffic; a refused issue request is held until accepted
        for (int n = 0; n < 300; n++) begin
            if (!(ifa.ISSUE_VALID && !last_acc)) begin
                ifa.ISSUE_VALID = 1'($urandom_range(0, 1));
                ifa.ISSUE_DR    = 3'($urandom_range(0, 7));
            end
            ifa.LD_REG = ($urandom_range(0, 2) != 0);
            ifa.DR     = 3'($urandom_range(0, 7));
            ifa.BUS    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            ifa.LD_CC  = 1'($urandom_range(0, 1));
            ifa.SR_SEL = 6'($urandom);
            tick("rnd");
        end

        // Wide three-port instance
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0);
        for (int i = 0; i < 16; i++) begin
            ifc.LD_REG = 1'b1;
            ifc.DR     = 4'(i);
            ifc.BUS    = 32'(i) * 32'h01010101;
            @(posedge Clk);
            #1;
        end
        ifc.LD_REG = 1'b0;
        for (int k = 0; k < 24; k++) begin
            case (k)
                0: begin sv[0] = 4'd0;  sv[1] = 4'd0;  sv[2] = 4'd0;  end
                1: begin sv[0] = 4'd15; sv[1] = 4'd15; sv[2] = 4'd15; end
                2: begin sv[0] = 4'd1;  sv[1] = 4'd2;  sv[2] = 4'd3;  end
                3: begin sv[0] = 4'd7;  sv[1] = 4'd12; sv[2] = 4'd7;  end
                default: for (int p = 0; p < 3; p++) sv[p] = 4'($urandom_range(0, 15));
            endcase
            ifc.SR_SEL = {sv[2], sv[1], sv[0]};
            #1;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("wide_k%0d_p%0d", k, p), ifc.SR_OUT[p*32 +: 32],
                    32'(sv[p]) * 32'h01010101);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
